// File: rtl/pipearch_pkg.sv
// Shared types and instruction-word field positions for the pipearch blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipearch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FORWARD = 2'd1,
      DONE    = 2'd2
   } t_fanout_state;

   typedef enum logic [1:0] {
      PASS   = 2'd0,
      REBASE = 2'd1,
      CONCAT = 2'd2,
      DROP   = 2'd3
   } t_fanout_mode;

   // Counter width shared by lines and iterations.
   localparam int REG_CNT_W = 16;

   // regs[0]: lines per iteration and iteration count.
   localparam int REG_LINES_LSB = 0;
   localparam int REG_ITERS_LSB = 16;

   // regs[1]: destination mask, mode and address base.
   localparam int REG_MASK_LSB = 0;
   localparam int REG_MASK_W   = 8;
   localparam int REG_MODE_LSB = 8;
   localparam int REG_MODE_W   = 2;
   localparam int REG_BASE_LSB = 16;
   localparam int REG_BASE_W   = 16;

endpackage

// File: rtl/pipearch_fwd_addrgen.sv
// Address generator and data stage: holds base/offset, forms the wrapped
// destination address and registers it together with data and fifobram select.
// Latency: 1 cycle src -> dst. Backpressure: none, follows src every cycle.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   load, base          latch a new base and clear the offset (instruction start)
//   advance, step       add step (lines per iteration) to the offset
//   mode                latched instruction mode, selects the address formula
//   src_waddr/wdata/wfifobram   source write fields
//   dst_waddr/wdata/wfifobram   registered destination write fields
module pipearch_fwd_addrgen
   import pipearch_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 512
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] base,
   input  logic              advance,
   input  logic [ADDR_W-1:0] step,
   input  t_fanout_mode      mode,
   input  logic [ADDR_W-1:0] src_waddr,
   input  logic [DATA_W-1:0] src_wdata,
   input  logic              src_wfifobram,
   output logic [ADDR_W-1:0] dst_waddr,
   output logic [DATA_W-1:0] dst_wdata,
   output logic              dst_wfifobram
);

   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] offset_q;
   logic [ADDR_W-1:0] addr_next;

   // All sums are ADDR_W wide so they wrap modulo 2^ADDR_W.
   always_comb begin
      addr_next = src_waddr;
      case (mode)
         PASS:    addr_next = src_waddr;
         REBASE:  addr_next = src_waddr + base_q;
         CONCAT:  addr_next = src_waddr + base_q + offset_q;
         default: addr_next = src_waddr;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_q        <= '0;
         offset_q      <= '0;
         dst_waddr     <= '0;
         dst_wdata     <= '0;
         dst_wfifobram <= 1'b0;
      end else begin
         if (load) begin
            base_q   <= base;
            offset_q <= '0;
         end else if (advance) begin
            // The current line still uses the old offset; the new one
            // applies from the first line of the next iteration.
            offset_q <= offset_q + step;
         end
         dst_waddr     <= addr_next;
         dst_wdata     <= src_wdata;
         dst_wfifobram <= src_wfifobram;
      end
   end

endmodule

// File: rtl/pipearch_writefanout.sv
// Write fan-out: forwards lines x iterations from one source write port to a
// masked subset of NUM_DST destinations, with pass/rebase/concat/drop addressing.
// Latency: 1 cycle src -> dst. Backpressure: none, destinations accept every cycle.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   op_start, regs   instruction start and its two 32-bit words
//   op_done, busy    one-cycle completion pulse, not-IDLE indicator
//   src_*            source write port
//   dst_we           per-destination write strobe; dst_waddr/wdata/wfifobram shared
module pipearch_writefanout
   import pipearch_pkg::*;
#(
   parameter int NUM_DST = 2,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 512
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               op_start,
   output logic               op_done,
   output logic               busy,
   input  logic [1:0][31:0]   regs,
   input  logic               src_we,
   input  logic [ADDR_W-1:0]  src_waddr,
   input  logic [DATA_W-1:0]  src_wdata,
   input  logic               src_wfifobram,
   output logic [NUM_DST-1:0] dst_we,
   output logic [ADDR_W-1:0]  dst_waddr,
   output logic [DATA_W-1:0]  dst_wdata,
   output logic               dst_wfifobram
);

   t_fanout_state          state;
   t_fanout_mode           mode_q;
   logic [REG_CNT_W-1:0]   lines_q;
   logic [REG_CNT_W-1:0]   iters_q;
   logic [REG_CNT_W-1:0]   line_cnt;
   logic [REG_CNT_W-1:0]   iter_cnt;
   logic [NUM_DST-1:0]     mask_q;

   // Instruction fields decoded straight from the regs words.
   logic [REG_CNT_W-1:0]   op_lines;
   logic [REG_CNT_W-1:0]   op_iters;
   logic [NUM_DST-1:0]     op_mask;
   t_fanout_mode           op_mode;
   logic [ADDR_W-1:0]      op_base;

   logic accept;
   logic fwd_we;
   logic line_last;
   logic iter_last;
   logic advance;
   logic unused_regs;

   assign op_lines = regs[0][REG_LINES_LSB +: REG_CNT_W];
   assign op_iters = regs[0][REG_ITERS_LSB +: REG_CNT_W];
   // Mask bits at or above NUM_DST have no destination and are dropped here.
   assign op_mask  = regs[1][REG_MASK_LSB +: NUM_DST];
   assign op_mode  = t_fanout_mode'(regs[1][REG_MODE_LSB +: REG_MODE_W]);
   assign op_base  = regs[1][REG_BASE_LSB +: ADDR_W];

   // Reserved and out-of-range fields are intentionally ignored.
   assign unused_regs = ^regs;

   assign accept    = (state == IDLE) && op_start;
   assign fwd_we    = (state == FORWARD) && src_we;
   // Compare against count-1 so a full 0xFFFF count needs no 17th bit.
   assign line_last = (line_cnt == lines_q - 16'd1);
   assign iter_last = (iter_cnt == iters_q - 16'd1);
   assign advance   = fwd_we && line_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         mode_q   <= PASS;
         lines_q  <= '0;
         iters_q  <= '0;
         line_cnt <= '0;
         iter_cnt <= '0;
         mask_q   <= '0;
         dst_we   <= '0;
         op_done  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         op_done <= 1'b0;
         dst_we  <= '0;
         case (state)
            IDLE: begin
               if (op_start) begin
                  lines_q  <= op_lines;
                  iters_q  <= op_iters;
                  mask_q   <= op_mask;
                  mode_q   <= op_mode;
                  line_cnt <= '0;
                  iter_cnt <= '0;
                  busy     <= 1'b1;
                  if (op_lines == '0 || op_iters == '0)
                     state <= DONE;
                  else
                     state <= FORWARD;
               end
            end
            FORWARD: begin
               if (src_we) begin
                  // A zero mask naturally writes nothing, same as DROP.
                  dst_we <= (mode_q == DROP) ? '0 : mask_q;
                  if (line_last) begin
                     line_cnt <= '0;
                     if (iter_last) begin
                        // op_done lines up with the final dst_we.
                        op_done <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                     end else begin
                        iter_cnt <= iter_cnt + 16'd1;
                     end
                  end else begin
                     line_cnt <= line_cnt + 16'd1;
                  end
               end
            end
            DONE: begin
               op_done <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   pipearch_fwd_addrgen #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_addrgen (
      .clk           (clk),
      .reset         (reset),
      .load          (accept),
      .base          (op_base),
      .advance       (advance),
      .step          (lines_q[ADDR_W-1:0]),
      .mode          (mode_q),
      .src_waddr     (src_waddr),
      .src_wdata     (src_wdata),
      .src_wfifobram (src_wfifobram),
      .dst_waddr     (dst_waddr),
      .dst_wdata     (dst_wdata),
      .dst_wfifobram (dst_wfifobram)
   );

endmodule

// File: tb/tb_pipearch_writefanout.sv
// Directed bench for pipearch_writefanout (NUM_DST=2, ADDR_W=10, DATA_W=512).
// Inputs change 1 time unit after the rising edge; outputs are read at the
// same point, so each step shows the result of the previous cycle's inputs.
module tb_pipearch_writefanout;

   logic             clk = 1'b0;
   logic             reset;
   logic             op_start;
   logic             op_done;
   logic             busy;
   logic [1:0][31:0] regs;
   logic             src_we;
   logic [9:0]       src_waddr;
   logic [511:0]     src_wdata;
   logic             src_wfifobram;
   logic [1:0]       dst_we;
   logic [9:0]       dst_waddr;
   logic [511:0]     dst_wdata;
   logic             dst_wfifobram;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipearch_writefanout #(
      .NUM_DST (2),
      .ADDR_W  (10),
      .DATA_W  (512)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .op_start      (op_start),
      .op_done       (op_done),
      .busy          (busy),
      .regs          (regs),
      .src_we        (src_we),
      .src_waddr     (src_waddr),
      .src_wdata     (src_wdata),
      .src_wfifobram (src_wfifobram),
      .dst_we        (dst_we),
      .dst_waddr     (dst_waddr),
      .dst_wdata     (dst_wdata),
      .dst_wfifobram (dst_wfifobram)
   );

   function automatic logic [511:0] pat(input int i);
      logic [31:0] w;
      w = 32'hC0DE_0000 | 32'(i);
      return {16{w}};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one instruction; returns one step after the accepting edge.
   task automatic start_op(input logic [15:0] lines, input logic [15:0] iters,
                           input logic [7:0] mask, input logic [1:0] mode,
                           input logic [15:0] base);
      regs[0]  = {iters, lines};
      regs[1]  = {base, 6'd0, mode, mask};
      op_start = 1'b1;
      step();
      op_start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      src_we = 1'b1; src_waddr = 10'h155; src_wdata = pat(99); src_wfifobram = 1'b1;
      op_start = 1'b1;
      step(); step();
      total++;
      if (dst_we !== 2'b00 || op_done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL reset_ctrl we=%b done=%b busy=%b exp 00/0/0", dst_we, op_done, busy);
      end
      total++;
      if (dst_waddr !== 10'h0 || dst_wdata !== 512'h0 || dst_wfifobram !== 1'b0) begin
         bad++; $display("FAIL reset_data addr=%h fb=%b exp 000/0 (data zero)", dst_waddr, dst_wfifobram);
      end
      src_we = 1'b0; op_start = 1'b0; src_wfifobram = 1'b0;
      #3 reset = 1'b0;
      step();
   endtask

   task automatic test_pass();
      start_op(16'd4, 16'd2, 8'h03, 2'd0, 16'h0000);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL pass_busy_rise got=%b exp=1", busy); end
      for (int i = 0; i < 8; i++) begin
         src_we = 1'b1; src_waddr = 10'(i % 4); src_wdata = pat(i); src_wfifobram = i[0];
         step();
         total++;
         if (dst_we !== 2'b11 || dst_waddr !== 10'(i % 4) || dst_wdata !== pat(i) || dst_wfifobram !== i[0]) begin
            bad++; $display("FAIL pass_write[%0d] we=%b addr=%h fb=%b exp we=11 addr=%h fb=%b",
                            i, dst_we, dst_waddr, dst_wfifobram, 10'(i % 4), i[0]);
         end
         total++;
         if (op_done !== (i == 7) || busy !== (i != 7)) begin
            bad++; $display("FAIL pass_done[%0d] done=%b busy=%b exp done=%b busy=%b",
                            i, op_done, busy, (i == 7), (i != 7));
         end
      end
      src_we = 1'b0;
      step();
      total++;
      if (op_done !== 1'b0 || dst_we !== 2'b00) begin
         bad++; $display("FAIL pass_after done=%b we=%b exp 0/00", op_done, dst_we);
      end
   endtask

   task automatic test_concat();
      logic [9:0] exp_addr [9];
      exp_addr = '{10'h100, 10'h101, 10'h102, 10'h103, 10'h104, 10'h105, 10'h106, 10'h107, 10'h108};
      start_op(16'd3, 16'd3, 8'h01, 2'd2, 16'h0100);
      for (int i = 0; i < 9; i++) begin
         src_we = 1'b1; src_waddr = 10'(i % 3); src_wdata = pat(i + 20);
         step();
         total++;
         if (dst_we !== 2'b01 || dst_waddr !== exp_addr[i] || op_done !== (i == 8)) begin
            bad++; $display("FAIL concat[%0d] we=%b addr=%h done=%b exp we=01 addr=%h done=%b",
                            i, dst_we, dst_waddr, op_done, exp_addr[i], (i == 8));
         end
      end
      src_we = 1'b0;
      step();
   endtask

   task automatic test_rebase();
      logic [9:0] exp_addr [4];
      exp_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
      // Upper mask bits beyond NUM_DST must have no effect.
      start_op(16'd4, 16'd1, 8'hF2, 2'd1, 16'h03FE);
      for (int i = 0; i < 4; i++) begin
         src_we = 1'b1; src_waddr = 10'(i);
         step();
         total++;
         if (dst_we !== 2'b10 || dst_waddr !== exp_addr[i] || op_done !== (i == 3)) begin
            bad++; $display("FAIL rebase[%0d] we=%b addr=%h done=%b exp we=10 addr=%h done=%b",
                            i, dst_we, dst_waddr, op_done, exp_addr[i], (i == 3));
         end
      end
      src_we = 1'b0;
      step();
   endtask

   task automatic test_drop();
      logic we_pat [9];
      int   n;
      we_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      n = 0;
      start_op(16'd5, 16'd1, 8'h03, 2'd3, 16'h0000);
      for (int c = 0; c < 9; c++) begin
         src_we = we_pat[c]; src_waddr = 10'(c);
         if (we_pat[c]) n++;
         step();
         total++;
         if (dst_we !== 2'b00 || op_done !== (we_pat[c] && n == 5)) begin
            bad++; $display("FAIL drop[%0d] we=%b done=%b exp we=00 done=%b",
                            c, dst_we, op_done, (we_pat[c] && n == 5));
         end
      end
      src_we = 1'b0;
      step();
      total++;
      if (busy !== 1'b0 || op_done !== 1'b0) begin
         bad++; $display("FAIL drop_end busy=%b done=%b exp 0/0", busy, op_done);
      end
   endtask

   task automatic test_zero_count();
      for (int k = 0; k < 2; k++) begin
         if (k == 0) start_op(16'd0, 16'd3, 8'h03, 2'd0, 16'h0000);
         else        start_op(16'd2, 16'd0, 8'h03, 2'd0, 16'h0000);
         total++;
         if (busy !== 1'b1 || op_done !== 1'b0) begin
            bad++; $display("FAIL zero[%0d]_start+1 busy=%b done=%b exp 1/0", k, busy, op_done);
         end
         src_we = 1'b1; src_waddr = 10'h3;
         step();
         total++;
         if (op_done !== 1'b1 || busy !== 1'b0 || dst_we !== 2'b00) begin
            bad++; $display("FAIL zero[%0d]_start+2 done=%b busy=%b we=%b exp 1/0/00", k, op_done, busy, dst_we);
         end
         src_we = 1'b0;
         step();
         total++;
         if (op_done !== 1'b0) begin
            bad++; $display("FAIL zero[%0d]_pulse done=%b exp 0", k, op_done);
         end
      end
   endtask

   task automatic test_idle_we();
      for (int i = 0; i < 3; i++) begin
         src_we = 1'b1; src_waddr = 10'h2A + 10'(i); src_wdata = pat(40 + i); src_wfifobram = 1'b1;
         step();
         total++;
         if (dst_we !== 2'b00 || busy !== 1'b0 || dst_waddr !== 10'h2A + 10'(i) ||
             dst_wdata !== pat(40 + i) || dst_wfifobram !== 1'b1) begin
            bad++; $display("FAIL idle_we[%0d] we=%b busy=%b addr=%h fb=%b exp we=00 busy=0 addr=%h fb=1",
                            i, dst_we, busy, dst_waddr, dst_wfifobram, 10'h2A + 10'(i));
         end
      end
      src_we = 1'b0; src_wfifobram = 1'b0;
   endtask

   task automatic test_start_while_busy();
      start_op(16'd2, 16'd1, 8'h03, 2'd0, 16'h0000);
      // A second instruction (1 line, DROP) arrives while busy.
      regs[0] = {16'd1, 16'd1};
      regs[1] = {16'h0040, 6'd0, 2'd3, 8'h01};
      op_start = 1'b1;
      src_we = 1'b1; src_waddr = 10'h5;
      step();
      op_start = 1'b0;
      total++;
      if (dst_we !== 2'b11 || dst_waddr !== 10'h5 || op_done !== 1'b0) begin
         bad++; $display("FAIL busy_start_w0 we=%b addr=%h done=%b exp 11/005/0", dst_we, dst_waddr, op_done);
      end
      src_waddr = 10'h6;
      step();
      total++;
      if (dst_we !== 2'b11 || dst_waddr !== 10'h6 || op_done !== 1'b1) begin
         bad++; $display("FAIL busy_start_w1 we=%b addr=%h done=%b exp 11/006/1", dst_we, dst_waddr, op_done);
      end
      src_we = 1'b0;
      step();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL busy_start_end busy=%b exp 0", busy); end
   endtask

   task automatic test_back_to_back();
      start_op(16'd1, 16'd1, 8'h01, 2'd0, 16'h0000);
      src_we = 1'b1; src_waddr = 10'h7;
      step();
      src_we = 1'b0;
      total++;
      if (op_done !== 1'b1 || dst_we !== 2'b01) begin
         bad++; $display("FAIL b2b_first done=%b we=%b exp 1/01", op_done, dst_we);
      end
      // op_start in the first IDLE cycle, which is the op_done cycle.
      start_op(16'd2, 16'd1, 8'h02, 2'd1, 16'h0010);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept busy=%b exp 1", busy); end
      for (int i = 0; i < 2; i++) begin
         src_we = 1'b1; src_waddr = 10'(i);
         step();
         total++;
         if (dst_we !== 2'b10 || dst_waddr !== 10'h10 + 10'(i) || op_done !== (i == 1)) begin
            bad++; $display("FAIL b2b_second[%0d] we=%b addr=%h done=%b exp we=10 addr=%h done=%b",
                            i, dst_we, dst_waddr, op_done, 10'h10 + 10'(i), (i == 1));
         end
      end
      src_we = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      start_op(16'd3, 16'd3, 8'h03, 2'd2, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         src_we = 1'b1; src_waddr = 10'(i % 3); src_wdata = pat(60 + i); src_wfifobram = 1'b1;
         step();
      end
      total++;
      if (dst_we !== 2'b11 || dst_waddr !== 10'h003 || busy !== 1'b1) begin
         bad++; $display("FAIL rmid_pre we=%b addr=%h busy=%b exp 11/003/1", dst_we, dst_waddr, busy);
      end
      src_waddr = 10'h1;
      #2 reset = 1'b1;
      #1;
      total++;
      if (dst_we !== 2'b00 || op_done !== 1'b0 || busy !== 1'b0 ||
          dst_waddr !== 10'h0 || dst_wdata !== 512'h0 || dst_wfifobram !== 1'b0) begin
         bad++; $display("FAIL rmid_async we=%b done=%b busy=%b addr=%h fb=%b exp all zero",
                         dst_we, op_done, busy, dst_waddr, dst_wfifobram);
      end
      #2 reset = 1'b0;
      src_we = 1'b0; src_wfifobram = 1'b0;
      step();
      total++;
      if (op_done !== 1'b0 || busy !== 1'b0 || dst_we !== 2'b00) begin
         bad++; $display("FAIL rmid_after done=%b busy=%b we=%b exp 0/0/00", op_done, busy, dst_we);
      end
      start_op(16'd2, 16'd2, 8'h01, 2'd2, 16'h0020);
      for (int i = 0; i < 4; i++) begin
         src_we = 1'b1; src_waddr = 10'(i % 2);
         step();
         total++;
         if (dst_we !== 2'b01 || dst_waddr !== 10'h20 + 10'(i) || op_done !== (i == 3)) begin
            bad++; $display("FAIL rmid_next[%0d] we=%b addr=%h done=%b exp we=01 addr=%h done=%b",
                            i, dst_we, dst_waddr, op_done, 10'h20 + 10'(i), (i == 3));
         end
      end
      src_we = 1'b0;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; op_start = 1'b0; regs = '0;
      src_we = 1'b0; src_waddr = '0; src_wdata = '0; src_wfifobram = 1'b0;
      test_reset();
      test_pass();
      test_concat();
      test_rebase();
      test_drop();
      test_zero_count();
      test_idle_we();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
